// File: rtl/ram_pkg.sv
// ram_pkg
// Shared types and helpers for the parametrised simple-dual-port RAM.
//   ram_state_e : controller state (init sweep / ready for traffic)
//   RDW_OLD/NEW : values of the RDW_MODE parameter
//   par_f       : even parity of a word (zero-extended to PAR_MAX_W bits)
// Optional feature macro used by the RAM files: RAM_PARITY_EN.

package ram_pkg;

    typedef enum logic {
        RAM_INIT,
        RAM_READY
    } ram_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest data word par_f can cover; callers zero-extend, which does
    // not change the parity.
    localparam int PAR_MAX_W = 256;

    function automatic logic par_f(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ram_dp_param_if.sv
// ram_dp_param_if
// Bundles the write port, the read port and the status outputs of
// ram_dp_param.
//   enb, wr, rd           : global enable, write request, read request
//   w_addr, w_data        : write address / data
//   r_addr                : read address
//   r_data, r_valid       : read data (held between reads) and valid pulse
//   init_busy, addr_err   : init sweep in progress / out-of-range pulse
//   par_inj, par_err      : parity inject / parity error (RAM_PARITY_EN only)
// modport master drives requests, modport slave is the RAM side.
// Optional feature macro: RAM_PARITY_EN.

interface ram_dp_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);

    logic              enb;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              init_busy;
    logic              addr_err;
`ifdef RAM_PARITY_EN
    logic              par_inj;
    logic              par_err;
`endif

    modport master (
        output enb, wr, rd, w_addr, r_addr, w_data,
`ifdef RAM_PARITY_EN
        output par_inj,
        input  par_err,
`endif
        input  r_data, r_valid, init_busy, addr_err
    );

    modport slave (
        input  enb, wr, rd, w_addr, r_addr, w_data,
`ifdef RAM_PARITY_EN
        input  par_inj,
        output par_err,
`endif
        output r_data, r_valid, init_busy, addr_err
    );

endinterface

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe
// RD_LAT-deep (1 or 2) shift register carrying the read valid, the read
// data and the parity-error flag from the array to the read port.
//   clk, rst        : clock, asynchronous active-low reset (flushes stages)
//   in_valid        : a read was accepted this cycle
//   in_data         : word read from the array (0 for out-of-range)
//   in_perr         : parity mismatch of that word (RAM_PARITY_EN only)
//   out_valid       : one-cycle pulse RD_LAT cycles after in_valid
//   out_data        : read data, held between reads
//   out_perr        : parity error, only ever 1 with out_valid
// Optional feature macro: RAM_PARITY_EN.

module ram_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
`ifdef RAM_PARITY_EN
    input  logic              in_perr,
    output logic              out_perr,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
`ifdef RAM_PARITY_EN
    logic              s1_perr;
`endif

    // First stage: data only loads on a valid read so the port holds the
    // last returned word between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
`ifdef RAM_PARITY_EN
            s1_perr  <= 1'b0;
`endif
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
            end
`ifdef RAM_PARITY_EN
            s1_perr  <= in_valid & in_perr;
`endif
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_valid;
            logic [DATA_W-1:0] s2_data;
`ifdef RAM_PARITY_EN
            logic              s2_perr;
`endif

            // Optional output register stage.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
`ifdef RAM_PARITY_EN
                    s2_perr  <= 1'b0;
`endif
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
`ifdef RAM_PARITY_EN
                    s2_perr  <= s1_valid & s1_perr;
`endif
                end
            end

            assign out_valid = s2_valid;
            assign out_data  = s2_data;
`ifdef RAM_PARITY_EN
            assign out_perr  = s2_perr;
`endif
        end else begin : g_lat1
            assign out_valid = s1_valid;
            assign out_data  = s1_data;
`ifdef RAM_PARITY_EN
            assign out_perr  = s1_perr;
`endif
        end
    endgenerate

endmodule

// File: rtl/ram_dp_param.sv
// ram_dp_param
// Parametrised simple-dual-port synchronous RAM (one write port, one read
// port). After reset a hardware sweep zeroes every word, one per cycle,
// before traffic is accepted. Out-of-range requests are flagged on
// addr_err; bad writes are dropped and bad reads return 0.
// Parameters: DATA_W, ADDR_W, DEPTH (<= 2**ADDR_W), RD_LAT (1 or 2),
//             RDW_MODE (RDW_OLD / RDW_NEW for same-address read+write).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : ram_dp_param_if.slave (requests, read data, status)
// Optional feature macro: RAM_PARITY_EN adds a stored even-parity bit per
// word, the par_inj input and the par_err output.

module ram_dp_param
    import ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 16,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    ram_dp_param_if.slave bus
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
`ifdef RAM_PARITY_EN
    localparam int                WORD_W   = DATA_W + 1;
`else
    localparam int                WORD_W   = DATA_W;
`endif

    logic [WORD_W-1:0] mem [0:DEPTH-1];

    ram_state_e        state;
    logic [IDX_W-1:0]  cnt;
    logic              init_busy_q;
    logic              addr_err_q;

    logic              wr_req;
    logic              rd_req;
    logic              w_ok;
    logic              r_ok;
    logic              wr_fire;
    logic              rd_fire;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] rd_word;

    // Requests only count once the sweep has finished.
    assign wr_req  = (state == RAM_READY) && bus.enb && bus.wr;
    assign rd_req  = (state == RAM_READY) && bus.enb && bus.rd;
    assign w_ok    = {1'b0, bus.w_addr} < DEPTH_V;
    assign r_ok    = {1'b0, bus.r_addr} < DEPTH_V;
    assign wr_fire = wr_req && w_ok;
    assign rd_fire = rd_req;
    assign w_idx   = bus.w_addr[IDX_W-1:0];
    assign r_idx   = bus.r_addr[IDX_W-1:0];

`ifdef RAM_PARITY_EN
    // par_inj flips the stored bit so a later read reports a mismatch.
    assign w_word = {par_f(PAR_MAX_W'(bus.w_data)) ^ bus.par_inj, bus.w_data};
`else
    assign w_word = bus.w_data;
`endif

    // Controller: init sweep then ready. init_busy and addr_err are
    // registered; addr_err is one pulse per cycle even if both ports are bad.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RAM_INIT;
            cnt         <= '0;
            init_busy_q <= 1'b1;
            addr_err_q  <= 1'b0;
        end else begin
            addr_err_q <= (wr_req && !w_ok) || (rd_req && !r_ok);
            case (state)
                RAM_INIT: begin
                    cnt <= cnt + IDX_W'(1);
                    if (cnt == LAST_IDX) begin
                        state       <= RAM_READY;
                        init_busy_q <= 1'b0;
                    end
                end
                RAM_READY: begin
                end
            endcase
        end
    end

    // Array write port. Contents are deliberately not reset; the sweep
    // clears them one word per cycle instead (all-zero word has parity 0).
    always_ff @(posedge clk) begin
        if (state == RAM_INIT) begin
            mem[cnt] <= '0;
        end else if (wr_fire) begin
            mem[w_idx] <= w_word;
        end
    end

    // Array read port. Out-of-range reads return 0; in new-data mode a
    // same-address write in the same cycle bypasses the array.
    always_comb begin
        rd_word = '0;
        if (r_ok) begin
            rd_word = mem[r_idx];
            if ((RDW_MODE == RDW_NEW) && wr_fire && (bus.w_addr == bus.r_addr)) begin
                rd_word = w_word;
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic rd_perr;

    assign rd_perr = rd_word[DATA_W] ^ par_f(PAR_MAX_W'(rd_word[DATA_W-1:0]));
`endif

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_fire),
        .in_data   (rd_word[DATA_W-1:0]),
`ifdef RAM_PARITY_EN
        .in_perr   (rd_perr),
        .out_perr  (bus.par_err),
`endif
        .out_valid (bus.r_valid),
        .out_data  (bus.r_data)
    );

    assign bus.init_busy = init_busy_q;
    assign bus.addr_err  = addr_err_q;

endmodule
